// File: rtl/alu_rs.sv
// alu_rs: ALU reservation station with CDB wakeup and a registered valid/ready issue stage
module alu_rs #(
    parameter int RS_SIZE = 8,
    parameter int DATA_W  = 32,
    parameter int TAG_W   = 4,
    parameter int NAME_W  = 5,
    parameter int OP_W    = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              alloc_en,
    input  logic [OP_W-1:0]   alloc_op,
    input  logic [NAME_W-1:0] alloc_name,
    input  logic [TAG_W-1:0]  alloc_tag,
    input  logic              alloc_rdy1,
    input  logic              alloc_rdy2,
    input  logic [DATA_W-1:0] alloc_val1,
    input  logic [DATA_W-1:0] alloc_val2,
    input  logic [TAG_W-1:0]  alloc_src1,
    input  logic [TAG_W-1:0]  alloc_src2,
    output logic              full,
    input  logic              cdb_en,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,
    output logic              issue_valid,
    input  logic              issue_ready,
    output logic [OP_W-1:0]   issue_op,
    output logic [DATA_W-1:0] issue_a,
    output logic [DATA_W-1:0] issue_b,
    output logic [NAME_W-1:0] issue_name,
    output logic [TAG_W-1:0]  issue_tag
);
    localparam int IW = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

    logic [RS_SIZE-1:0] busy_q, busy_d, rdy1_q, rdy1_d, rdy2_q, rdy2_d;
    logic [OP_W-1:0]    op_q   [RS_SIZE];
    logic [OP_W-1:0]    op_d   [RS_SIZE];
    logic [NAME_W-1:0]  name_q [RS_SIZE];
    logic [NAME_W-1:0]  name_d [RS_SIZE];
    logic [TAG_W-1:0]   tag_q  [RS_SIZE];
    logic [TAG_W-1:0]   tag_d  [RS_SIZE];
    logic [TAG_W-1:0]   src1_q [RS_SIZE];
    logic [TAG_W-1:0]   src1_d [RS_SIZE];
    logic [TAG_W-1:0]   src2_q [RS_SIZE];
    logic [TAG_W-1:0]   src2_d [RS_SIZE];
    logic [DATA_W-1:0]  val1_q [RS_SIZE];
    logic [DATA_W-1:0]  val1_d [RS_SIZE];
    logic [DATA_W-1:0]  val2_q [RS_SIZE];
    logic [DATA_W-1:0]  val2_d [RS_SIZE];

    logic              issue_valid_q, issue_valid_d;
    logic [OP_W-1:0]   issue_op_q, issue_op_d;
    logic [DATA_W-1:0] issue_a_q, issue_a_d, issue_b_q, issue_b_d;
    logic [NAME_W-1:0] issue_name_q, issue_name_d;
    logic [TAG_W-1:0]  issue_tag_q, issue_tag_d;

    logic [IW-1:0] free_idx, iss_idx;
    logic          has_elig, load;

    assign full        = &busy_q;
    assign load        = !issue_valid_q || issue_ready;
    assign issue_valid = issue_valid_q;
    assign issue_op    = issue_op_q;
    assign issue_a     = issue_a_q;
    assign issue_b     = issue_b_q;
    assign issue_name  = issue_name_q;
    assign issue_tag   = issue_tag_q;

    // Priority pick of lowest free slot and lowest eligible slot from registered state
    always_comb begin
        free_idx = '0;
        iss_idx  = '0;
        has_elig = 1'b0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!busy_q[i]) free_idx = IW'(i);
            if (busy_q[i] && rdy1_q[i] && rdy2_q[i]) begin
                iss_idx  = IW'(i);
                has_elig = 1'b1;
            end
        end
    end

    // Next state: wakeup, issue into output stage, allocation with CDB bypass, flush last
    always_comb begin
        busy_d        = busy_q;
        rdy1_d        = rdy1_q;
        rdy2_d        = rdy2_q;
        op_d          = op_q;
        name_d        = name_q;
        tag_d         = tag_q;
        src1_d        = src1_q;
        src2_d        = src2_q;
        val1_d        = val1_q;
        val2_d        = val2_q;
        issue_valid_d = issue_valid_q;
        issue_op_d    = issue_op_q;
        issue_a_d     = issue_a_q;
        issue_b_d     = issue_b_q;
        issue_name_d  = issue_name_q;
        issue_tag_d   = issue_tag_q;
        for (int i = 0; i < RS_SIZE; i++) begin
            if (cdb_en && busy_q[i] && !rdy1_q[i] && src1_q[i] == cdb_tag) begin
                rdy1_d[i] = 1'b1;
                val1_d[i] = cdb_data;
            end
            if (cdb_en && busy_q[i] && !rdy2_q[i] && src2_q[i] == cdb_tag) begin
                rdy2_d[i] = 1'b1;
                val2_d[i] = cdb_data;
            end
        end
        if (load) begin
            issue_valid_d = has_elig;
            if (has_elig) begin
                busy_d[iss_idx] = 1'b0;
                issue_op_d      = op_q[iss_idx];
                issue_a_d       = val1_q[iss_idx];
                issue_b_d       = val2_q[iss_idx];
                issue_name_d    = name_q[iss_idx];
                issue_tag_d     = tag_q[iss_idx];
            end
        end
        if (alloc_en && !full) begin
            busy_d[free_idx] = 1'b1;
            op_d[free_idx]   = alloc_op;
            name_d[free_idx] = alloc_name;
            tag_d[free_idx]  = alloc_tag;
            src1_d[free_idx] = alloc_src1;
            src2_d[free_idx] = alloc_src2;
            rdy1_d[free_idx] = alloc_rdy1 || (cdb_en && alloc_src1 == cdb_tag);
            rdy2_d[free_idx] = alloc_rdy2 || (cdb_en && alloc_src2 == cdb_tag);
            val1_d[free_idx] = alloc_rdy1 ? alloc_val1 : cdb_data;
            val2_d[free_idx] = alloc_rdy2 ? alloc_val2 : cdb_data;
        end
        if (flush) begin
            busy_d        = '0;
            rdy1_d        = '0;
            rdy2_d        = '0;
            issue_valid_d = 1'b0;
            issue_op_d    = '0;
            issue_a_d     = '0;
            issue_b_d     = '0;
            issue_name_d  = '0;
            issue_tag_d   = '0;
        end
    end

    // Control and output-stage registers with active-low synchronous reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            busy_q        <= '0;
            rdy1_q        <= '0;
            rdy2_q        <= '0;
            issue_valid_q <= 1'b0;
            issue_op_q    <= '0;
            issue_a_q     <= '0;
            issue_b_q     <= '0;
            issue_name_q  <= '0;
            issue_tag_q   <= '0;
        end else begin
            busy_q        <= busy_d;
            rdy1_q        <= rdy1_d;
            rdy2_q        <= rdy2_d;
            issue_valid_q <= issue_valid_d;
            issue_op_q    <= issue_op_d;
            issue_a_q     <= issue_a_d;
            issue_b_q     <= issue_b_d;
            issue_name_q  <= issue_name_d;
            issue_tag_q   <= issue_tag_d;
        end
    end

    // Entry payload is only meaningful while busy, so it needs no reset
    always_ff @(posedge clk) begin
        op_q   <= op_d;
        name_q <= name_d;
        tag_q  <= tag_d;
        src1_q <= src1_d;
        src2_q <= src2_d;
        val1_q <= val1_d;
        val2_q <= val2_d;
    end
endmodule

// File: tb/tb_alu_rs.sv
// tb_alu_rs: directed cycle-vector bench for the ALU reservation station
module tb_alu_rs;
    logic        clk = 1'b0;
    logic        rst, flush, alloc_en, alloc_rdy1, alloc_rdy2;
    logic [4:0]  alloc_op, alloc_name, issue_op, issue_name;
    logic [3:0]  alloc_tag, alloc_src1, alloc_src2, cdb_tag, issue_tag;
    logic [31:0] alloc_val1, alloc_val2, cdb_data, issue_a, issue_b;
    logic        full, cdb_en, issue_valid, issue_ready;

    alu_rs #(.RS_SIZE(8), .DATA_W(32), .TAG_W(4), .NAME_W(5), .OP_W(5)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .alloc_en(alloc_en), .alloc_op(alloc_op), .alloc_name(alloc_name), .alloc_tag(alloc_tag),
        .alloc_rdy1(alloc_rdy1), .alloc_rdy2(alloc_rdy2),
        .alloc_val1(alloc_val1), .alloc_val2(alloc_val2),
        .alloc_src1(alloc_src1), .alloc_src2(alloc_src2),
        .full(full), .cdb_en(cdb_en), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
        .issue_a(issue_a), .issue_b(issue_b), .issue_name(issue_name), .issue_tag(issue_tag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rstn, ae, r1, r2, ce, ev;
        logic [4:0]  op, eop;
        logic [3:0]  tag, s1, s2, ct, etag;
        logic [31:0] v1, v2, cd, ea, eb;
    } vec_t;

    vec_t tv[18];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic vec_t mkv(input logic rstn, ae, input logic [4:0] op, input logic [3:0] tag,
                                 input logic r1, input logic [31:0] v1, input logic [3:0] s1,
                                 input logic r2, input logic [31:0] v2, input logic [3:0] s2,
                                 input logic ce, input logic [3:0] ct, input logic [31:0] cd,
                                 input logic ev, input logic [4:0] eop, input logic [3:0] etag,
                                 input logic [31:0] ea, eb);
        vec_t v;
        v.rstn = rstn; v.ae = ae; v.op = op; v.tag = tag;
        v.r1 = r1; v.v1 = v1; v.s1 = s1; v.r2 = r2; v.v2 = v2; v.s2 = s2;
        v.ce = ce; v.ct = ct; v.cd = cd;
        v.ev = ev; v.eop = eop; v.etag = etag; v.ea = ea; v.eb = eb;
        return v;
    endfunction

    function automatic vec_t idle(input logic ev, input logic [4:0] eop, input logic [3:0] etag,
                                  input logic [31:0] ea, eb);
        return mkv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ev, eop, etag, ea, eb);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        rst = v.rstn; flush = 1'b0; alloc_en = v.ae; alloc_op = v.op; alloc_tag = v.tag;
        alloc_name = {1'b0, v.tag} + 5'd1;
        alloc_rdy1 = v.r1; alloc_val1 = v.v1; alloc_src1 = v.s1;
        alloc_rdy2 = v.r2; alloc_val2 = v.v2; alloc_src2 = v.s2;
        cdb_en = v.ce; cdb_tag = v.ct; cdb_data = v.cd; issue_ready = 1'b1;
    endtask

    // Allocation of op t: op=t, name=t+1, a=t+100 (when ready), b=t+200
    task automatic put(input logic [3:0] t, input logic r1, input logic [3:0] s1);
        alloc_en = 1'b1; alloc_op = {1'b0, t}; alloc_tag = t; alloc_name = {1'b0, t} + 5'd1;
        alloc_rdy1 = r1; alloc_val1 = r1 ? 32'(t) + 32'd100 : 32'd0; alloc_src1 = s1;
        alloc_rdy2 = 1'b1; alloc_val2 = 32'(t) + 32'd200; alloc_src2 = 4'd0;
    endtask

    task automatic exp_iss(input string nm, input logic ev, input logic ef, input logic [3:0] t);
        chk({nm, ".valid"}, 64'(issue_valid), 64'(ev));
        chk({nm, ".full"}, 64'(full), 64'(ef));
        if (ev) begin
            chk({nm, ".tag"}, 64'(issue_tag), 64'(t));
            chk({nm, ".a"}, 64'(issue_a), 64'(t) + 64'd100);
            chk({nm, ".b"}, 64'(issue_b), 64'(t) + 64'd200);
            chk({nm, ".op"}, 64'(issue_op), 64'(t));
            chk({nm, ".name"}, 64'(issue_name), 64'(t) + 64'd1);
        end
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, ".tag0"}, 64'(issue_tag), 64'd0);
        chk({nm, ".a0"}, 64'(issue_a), 64'd0);
        chk({nm, ".b0"}, 64'(issue_b), 64'd0);
        chk({nm, ".op0"}, 64'(issue_op), 64'd0);
        chk({nm, ".name0"}, 64'(issue_name), 64'd0);
    endtask

    initial begin
        logic [3:0] ord[8];
        // reset, basic issue, wakeup, bypass, double wakeup alongside allocation
        tv[0]  = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tv[1]  = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tv[2]  = mkv(1, 1, 3, 2, 1, 5, 0, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tv[3]  = idle(1, 3, 2, 5, 7);
        tv[4]  = idle(0, 0, 0, 0, 0);
        tv[5]  = mkv(1, 1, 1, 3, 0, 0, 4, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tv[6]  = idle(0, 0, 0, 0, 0);
        tv[7]  = mkv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4, 32'h10, 0, 0, 0, 0, 0);
        tv[8]  = idle(1, 1, 3, 32'h10, 1);
        tv[9]  = idle(0, 0, 0, 0, 0);
        tv[10] = mkv(1, 1, 2, 5, 1, 32'h20, 0, 0, 0, 6, 1, 6, 9, 0, 0, 0, 0, 0);
        tv[11] = idle(1, 2, 5, 32'h20, 9);
        tv[12] = idle(0, 0, 0, 0, 0);
        tv[13] = mkv(1, 1, 4, 7, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        tv[14] = mkv(1, 1, 5, 8, 1, 3, 0, 1, 4, 0, 1, 1, 32'h55, 0, 0, 0, 0, 0);
        tv[15] = idle(1, 4, 7, 32'h55, 32'h55);
        tv[16] = idle(1, 5, 8, 3, 4);
        tv[17] = idle(0, 0, 0, 0, 0);
        for (int i = 0; i < 18; i++) begin
            drive(tv[i]);
            step;
            chk($sformatf("v%0d.valid", i), 64'(issue_valid), 64'(tv[i].ev));
            chk($sformatf("v%0d.full", i), 64'(full), 64'd0);
            if (tv[i].ev || !tv[i].rstn) begin
                chk($sformatf("v%0d.tag", i), 64'(issue_tag), 64'(tv[i].etag));
                chk($sformatf("v%0d.a", i), 64'(issue_a), 64'(tv[i].ea));
                chk($sformatf("v%0d.b", i), 64'(issue_b), 64'(tv[i].eb));
                chk($sformatf("v%0d.op", i), 64'(issue_op), 64'(tv[i].eop));
                chk($sformatf("v%0d.name", i), 64'(issue_name),
                    tv[i].rstn ? 64'(tv[i].etag) + 64'd1 : 64'd0);
            end
        end

        // Backpressure: tag 0 goes to the output stage, its slot is reused by tag 2
        drive(idle(0, 0, 0, 0, 0));
        rst = 1'b1;
        issue_ready = 1'b0;
        for (int k = 0; k < 9; k++) begin
            put(4'(k), 1'b1, 4'd0);
            step;
            exp_iss($sformatf("fill%0d", k), k >= 1, k == 8, 4'd0);
        end
        put(4'd9, 1'b1, 4'd0);
        $display("note: deliberate allocation while full (upstream protocol error)");
        step;
        exp_iss("drop", 1'b1, 1'b1, 4'd0);
        alloc_en = 1'b0;
        issue_ready = 1'b1;
        ord = '{4'd2, 4'd1, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
        for (int k = 0; k < 8; k++) begin
            step;
            exp_iss($sformatf("drain%0d", k), 1'b1, 1'b0, ord[k]);
        end
        step;
        exp_iss("drain_end", 1'b0, 1'b0, 4'd0);

        // Flush with allocation pending: nothing allocated, squashed tags never wake
        issue_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            put(4'(10 + k), k != 4, 4'd9);
            step;
            exp_iss($sformatf("pre_flush%0d", k), k >= 1, 1'b0, 4'd10);
        end
        flush = 1'b1;
        put(4'd15, 1'b1, 4'd0);
        issue_ready = 1'b1;
        step;
        exp_iss("flush", 1'b0, 1'b0, 4'd0);
        chk_zero("flush");
        flush = 1'b0;
        alloc_en = 1'b0;
        step;
        exp_iss("post_flush", 1'b0, 1'b0, 4'd0);
        cdb_en = 1'b1; cdb_tag = 4'd9; cdb_data = 32'd77;
        step;
        cdb_en = 1'b0;
        step;
        exp_iss("squash_wake1", 1'b0, 1'b0, 4'd0);
        step;
        exp_iss("squash_wake2", 1'b0, 1'b0, 4'd0);

        // Reset while full with a held output
        issue_ready = 1'b0;
        for (int k = 0; k < 9; k++) begin
            put(4'(k), 1'b1, 4'd0);
            step;
        end
        exp_iss("refill", 1'b1, 1'b1, 4'd0);
        alloc_en = 1'b0;
        rst = 1'b0;
        step;
        exp_iss("mid_reset", 1'b0, 1'b0, 4'd0);
        chk_zero("mid_reset");
        rst = 1'b1;
        issue_ready = 1'b1;
        step;
        step;
        exp_iss("after_reset", 1'b0, 1'b0, 4'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
